// File: rtl/tt_um_stochastic_test_cl123abc.sv
// ============================================================================
// Module  : tt_um_stochastic_test_cl123abc
// Brief   : Stochastic-computing multiplier tile. Two LFSR-encoded unipolar
//           streams are ANDed, and the ones are counted over a 255-cycle window.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_um_stochastic_test_cl123abc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] WIN_LAST  = 8'd254;

    logic [7:0] lfsr_a;
    logic [7:0] lfsr_b;
    logic [7:0] win;
    logic [7:0] acc;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result;

    logic       fb_a;
    logic       fb_b;
    logic       sa;
    logic       sb;
    logic       p;
    logic       win_end;
    logic [7:0] acc_sum;

    // Fibonacci taps: x^8+x^6+x^5+x^4+1 and x^8+x^4+x^3+x^2+1.
    assign fb_a    = lfsr_a[7] ^ lfsr_a[5] ^ lfsr_a[4] ^ lfsr_a[3];
    assign fb_b    = lfsr_b[7] ^ lfsr_b[3] ^ lfsr_b[2] ^ lfsr_b[1];

    assign sa      = (lfsr_a <= op_a);
    assign sb      = (lfsr_b <= op_b);
    assign p       = sa & sb;
    assign win_end = (win == WIN_LAST);

    // The largest possible window count is 255, so 8 bits never overflow.
    assign acc_sum = acc + {7'd0, p};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a <= LFSR_SEED;
            lfsr_b <= LFSR_SEED;
            win    <= 8'd0;
            acc    <= 8'd0;
            op_a   <= 8'd0;
            op_b   <= 8'd0;
            result <= 8'd0;
        end else if (ena) begin
            lfsr_a <= {lfsr_a[6:0], fb_a};
            lfsr_b <= {lfsr_b[6:0], fb_b};
            if (win_end) begin
                result <= acc_sum;
                acc    <= 8'd0;
                win    <= 8'd0;
                op_a   <= ui_in;
                op_b   <= uio_in;
            end else begin
                acc    <= acc_sum;
                win    <= win + 8'd1;
            end
        end
    end

    assign uo_out  = result;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_stochastic_test_cl123abc.sv
// ============================================================================
// Module  : tb_tt_um_stochastic_test_cl123abc
// Brief   : Directed self-checking bench for the stochastic multiplier tile.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tt_um_stochastic_test_cl123abc;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors;
    int miscompares;

    tt_um_stochastic_test_cl123abc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference count for one full window: both LFSRs walk their whole
    // period starting from the seed, so the count depends only on A and B.
    function automatic int golden(input int a, input int b);
        logic [7:0] la;
        logic [7:0] lb;
        int         cnt;
        la  = 8'h01;
        lb  = 8'h01;
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            if ((int'(la) <= a) && (int'(lb) <= b)) cnt++;
            la = {la[6:0], la[7] ^ la[5] ^ la[4] ^ la[3]};
            lb = {lb[6:0], lb[7] ^ lb[3] ^ lb[2] ^ lb[1]};
        end
        return cnt;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] a, input logic [7:0] b);
        ena    = 1'b1;
        ui_in  = a;
        uio_in = b;
        rst_n  = 1'b0;
        tick(3);
        @(negedge clk);
        rst_n  = 1'b1;
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset(8'd255, 8'd255);
        vectors++;
        if (uo_out !== 8'd0 || uio_oe !== 8'd0 || uio_out !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: uo_out=%0d uio_oe=%0d uio_out=%0d expected 0/0/0",
                     uo_out, uio_oe, uio_out);
        end
        for (int i = 1; i <= 255; i++) begin
            tick(1);
            vectors++;
            if (uo_out !== 8'd0) begin
                miscompares++;
                $display("FAIL first_window clk %0d: got %0d expected 0", i, uo_out);
            end
        end
        tick(254);
        vectors++;
        if (uo_out !== 8'd0) begin
            miscompares++;
            $display("FAIL pre_first_result clk 509: got %0d expected 0", uo_out);
        end
        tick(1);
        vectors++;
        if (uo_out !== 8'd255) begin
            miscompares++;
            $display("FAIL full_full clk 510: got %0d expected 255", uo_out);
        end
    endtask

    task automatic test_track_change();
        int bad;
        do_reset(8'd100, 8'd255);
        tick(510);
        vectors++;
        if (uo_out !== 8'd100) begin
            miscompares++;
            $display("FAIL a100_b255: got %0d expected 100", uo_out);
        end
        ui_in = 8'd37;
        bad   = 0;
        for (int i = 0; i < 510; i++) begin
            tick(1);
            if (uo_out !== 8'd100 && uo_out !== 8'd37) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL change_intermediate: got %0d bad samples expected 0", bad);
        end
        vectors++;
        if (uo_out !== 8'd37) begin
            miscompares++;
            $display("FAIL a37_b255: got %0d expected 37", uo_out);
        end
    endtask

    task automatic test_zero(input logic [7:0] a, input logic [7:0] b);
        do_reset(a, b);
        for (int w = 1; w <= 3; w++) begin
            tick(255);
            vectors++;
            if (uo_out !== 8'd0) begin
                miscompares++;
                $display("FAIL zero a=%0d b=%0d window %0d: got %0d expected 0", a, b, w, uo_out);
            end
        end
    endtask

    task automatic test_half_half();
        int exp;
        int r2;
        exp = golden(128, 128);
        do_reset(8'd128, 8'd128);
        tick(510);
        r2 = int'(uo_out);
        vectors++;
        if (uo_out !== exp[7:0]) begin
            miscompares++;
            $display("FAIL half_half window2: got %0d expected %0d", uo_out, exp);
        end
        tick(255);
        vectors++;
        if (int'(uo_out) !== r2) begin
            miscompares++;
            $display("FAIL half_half_stable: got %0d expected %0d", uo_out, r2);
        end
        vectors++;
        if (uo_out < 8'd52 || uo_out > 8'd76) begin
            miscompares++;
            $display("FAIL half_half_range: got %0d expected 52..76", uo_out);
        end
        check("golden_100_255", golden(100, 255), 100);
    endtask

    task automatic test_enable_freeze();
        int bad;
        do_reset(8'd100, 8'd255);
        tick(255);
        tick(100);
        ena = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (uo_out !== 8'd0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL freeze_hold: got %0d bad samples expected 0", bad);
        end
        ena = 1'b1;
        tick(154);
        vectors++;
        if (uo_out !== 8'd0) begin
            miscompares++;
            $display("FAIL freeze_pre_boundary: got %0d expected 0", uo_out);
        end
        tick(1);
        vectors++;
        if (uo_out !== 8'd100) begin
            miscompares++;
            $display("FAIL freeze_result: got %0d expected 100", uo_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset(8'd200, 8'd255);
        tick(510);
        vectors++;
        if (uo_out !== 8'd200) begin
            miscompares++;
            $display("FAIL pre_reset_result: got %0d expected 200", uo_out);
        end
        tick(50);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (uo_out !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %0d expected 0", uo_out);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        uio_in = 8'd255;
        ui_in  = 8'd55;
        #1;
        tick(510);
        vectors++;
        if (uo_out !== 8'd55) begin
            miscompares++;
            $display("FAIL post_reset_restart: got %0d expected 55", uo_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(8'd255, 8'd173);
        tick(510);
        vectors++;
        if (uo_out !== 8'd173) begin
            miscompares++;
            $display("FAIL a255_b173: got %0d expected 173", uo_out);
        end
        uio_in = 8'd9;
        tick(510);
        vectors++;
        if (uo_out !== 8'd9) begin
            miscompares++;
            $display("FAIL a255_b9: got %0d expected 9", uo_out);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ena         = 1'b0;
        ui_in       = 8'd0;
        uio_in      = 8'd0;
        test_reset();
        test_track_change();
        test_zero(8'd0, 8'd200);
        test_zero(8'd173, 8'd0);
        test_half_half();
        test_enable_freeze();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
